max_net_param: RTL and testbench
================================

# max_net_param

Parametrised winner-take-all (MaxNet) engine and the successor to the fixed 4-channel, 32-bit max network. It loads N signed fixed-point activations and iterates mutual inhibition with a runtime epsilon until at most one activation stays nonzero. It then reports a one-hot winner mask. Compared with the fixed block, it adds:
- an iteration limit with a timeout flag;
- an iteration count output;
- ReLU on load;
- optional tie-break.

## Interface
- N, 4: channel count, ≥2
- W, 32: activation width, signed two's complement
- FRAC, 16: fractional bits of activations and eps
- MAX_ITER, 64: iteration limit, ≥1
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  begin a run; sampled only in IDLE or DONE
- eps  input  W  inhibition weight, unsigned, FRAC fractional bits; sampled at LOAD
- x_init  input  N*W  packed initial activations, channel i at [i*W +: W]; sampled at LOAD
- busy  output  1  high in LOAD, SUM, UPD, CHK
- done  output  1  level, high in DONE until the next accepted start
- out  output  N  winner mask, bit i = channel i
- timeout  output  1  run ended at MAX_ITER with more than one survivor
- iter  output  $clog2(MAX_ITER+1)  completed iterations of the current or last run

## Operation
- States: IDLE, LOAD, SUM, UPD, CHK, DONE.
  - IDLE/DONE with start=1 → LOAD.
  - LOAD → CHK.
  - SUM → UPD → CHK.
  - CHK → DONE if survivors ≤1 or iter==MAX_ITER; else → SUM.
- LOAD:
  - x_i ← max(x_init_i, 0) (negative inputs clamp to 0).
  - Latch eps; clear iter, timeout, out.
- SUM: S ← Σ x_i, width W+$clog2(N), unsigned. No overflow is possible because every x_i ≥ 0.
- UPD, for every i in parallel:
  - inh_i = (eps × (S − x_i)) >> FRAC, full-precision product, truncated.
  - x_i ← (x_i > inh_i) ? x_i − inh_i : 0.
  - The compare is done at full width; no saturation is needed.
  - iter ← iter+1.
- CHK:
  - survivor mask m_i = (x_i ≠ 0).
  - On exit with popcount(m) ≤1: out ← m, timeout ← 0. All-zero inputs give out=0.
  - On exit at the limit: timeout ← 1, out ← m (multi-hot; see Configuration).
- out, timeout and iter hold their values in DONE.
- start asserted while busy is ignored.
- start in DONE restarts from LOAD.

## Timing
- Reset values: state IDLE, busy=0, done=0, out=0, timeout=0, iter=0, x_i=0, S=0.
- Accepted start at edge t:
  - LOAD at t+1, CHK at t+2.
  - Zero-iteration finish: done=1 from t+3.
- Each iteration costs 3 cycles (SUM, UPD, CHK). A run of k iterations asserts done from t+3+3k.
- Worst case: done at t+3+3·MAX_ITER.
- done and busy are never high together. out and timeout are valid whenever done=1.
- rst=1 in any state returns to the reset values on that edge. A run in progress is discarded.
- rst and start in the same cycle: rst wins and start is lost.

## Configuration
- MAXNET_TIE_BREAK_EN:
  - Defined: on timeout, out is one-hot at the lowest-index survivor; timeout is still set.
  - Undefined: on timeout, out is the full multi-hot survivor mask.
  - Non-timeout behaviour is identical in both cases.

## Test plan
- N=4, W=32, FRAC=16, eps=0x2000 (0.125), x_init = {0x0000C000, 0x00004000, 0x00008000, 0x00010000} (ch3..ch0 = 0.75, 0.25, 0.5, 1.0) → done with out=0001 and timeout=0.
  - After the first UPD: x = {0x00008800, 0, 0x00004000, 0x0000D000} (ch2 clamped to 0).
  - done rises exactly 3+3·iter cycles after start.
- Single positive input: ch2=0x00008000, others 0 → out=0100, iter=0, done at t+3.
- Negative clamp: ch0=0xFFFF0000 (−1.0), ch1=0x00004000, others 0 → out=0010, iter=0. All inputs zero → out=0000, timeout=0.
- Tie: all four inputs 0x00010000, eps=0x2000, MAX_ITER=8 → timeout=1, iter=8, done at t+27.
  - Macro undefined: out=1111.
  - Macro defined: out=0001.
- Protocol:
  - start pulsed during SUM is ignored.
  - rst asserted in UPD → next cycle IDLE, all outputs 0.
  - A new start after that completes normally.
  - start in DONE restarts the run; done drops at the next edge.

Source files
------------

// File: rtl/max_net_param.sv
// rtl/max_net_param.sv - parametrised MaxNet winner-take-all engine with iteration limit
// Optional feature macro: MAXNET_TIE_BREAK_EN (lowest-index winner on timeout)
module max_net_param #(
  parameter int N        = 4,
  parameter int W        = 32,
  parameter int FRAC     = 16,
  parameter int MAX_ITER = 64,
  localparam int IW      = $clog2(MAX_ITER + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   eps,
  input  logic [N*W-1:0] x_init,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   out,
  output logic           timeout,
  output logic [IW-1:0]  iter
);

  localparam int SW = W + $clog2(N);
  localparam int PW = W + SW;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SUM, S_UPD, S_CHK, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   x_q [N];
  logic [W-1:0]   eps_q;
  logic [SW-1:0]  sum_q;
  logic [IW-1:0]  iter_q;
  logic [N-1:0]   out_q;
  logic           timeout_q;

  logic [SW-1:0]  sum_c;
  logic [PW-1:0]  inh_c [N];
  logic [W-1:0]   x_upd_c [N];
  logic [N-1:0]   mask_c;
  logic [N-1:0]   win_c;
  logic [CW-1:0]  pop_c;
  logic           multi_c;
  logic           at_limit_c;
  logic           chk_exit_c;

  always_comb begin
    sum_c  = '0;
    mask_c = '0;
    pop_c  = '0;
    for (int i = 0; i < N; i++) begin
      sum_c     = sum_c + SW'(x_q[i]);
      mask_c[i] = (x_q[i] != '0);
      pop_c     = pop_c + CW'(mask_c[i]);
    end
    multi_c    = (pop_c > CW'(1));
    at_limit_c = (iter_q == IW'(MAX_ITER));
    chk_exit_c = !multi_c || at_limit_c;
  end

  // Inhibition uses the full-precision product; activations are never negative,
  // so the unsigned compare decides both the subtraction and the clamp to zero.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      inh_c[i]   = (PW'(eps_q) * PW'(sum_q - SW'(x_q[i]))) >> FRAC;
      x_upd_c[i] = (PW'(x_q[i]) > inh_c[i]) ? (x_q[i] - inh_c[i][W-1:0]) : '0;
    end
  end

`ifdef MAXNET_TIE_BREAK_EN
  always_comb begin
    win_c = mask_c;
    if (multi_c) begin
      win_c = '0;
      for (int i = N - 1; i >= 0; i--) begin
        if (mask_c[i]) begin
          win_c    = '0;
          win_c[i] = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    win_c = mask_c;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        busy    = 1'b1;
        state_d = S_CHK;
      end
      S_SUM: begin
        busy    = 1'b1;
        state_d = S_UPD;
      end
      S_UPD: begin
        busy    = 1'b1;
        state_d = S_CHK;
      end
      S_CHK: begin
        busy    = 1'b1;
        state_d = chk_exit_c ? S_DONE : S_SUM;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) x_q[i] <= '0;
      eps_q     <= '0;
      sum_q     <= '0;
      iter_q    <= '0;
      out_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          for (int i = 0; i < N; i++)
            x_q[i] <= x_init[i*W + W - 1] ? '0 : x_init[i*W +: W];
          eps_q     <= eps;
          iter_q    <= '0;
          out_q     <= '0;
          timeout_q <= 1'b0;
        end
        S_SUM: sum_q <= sum_c;
        S_UPD: begin
          for (int i = 0; i < N; i++) x_q[i] <= x_upd_c[i];
          iter_q <= iter_q + IW'(1);
        end
        S_CHK: begin
          if (chk_exit_c) begin
            out_q     <= win_c;
            timeout_q <= multi_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign out     = out_q;
  assign timeout = timeout_q;
  assign iter    = iter_q;

endmodule

// File: tb/tb_max_net_param.sv
// tb/tb_max_net_param.sv - scoreboard bench for max_net_param (MAX_ITER=8)
module tb_max_net_param;

  localparam int N        = 4;
  localparam int W        = 32;
  localparam int FRAC     = 16;
  localparam int MAX_ITER = 8;
  localparam int IW       = $clog2(MAX_ITER + 1);
  localparam int LIMIT    = 3 + 3 * MAX_ITER + 10;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   eps;
  logic [N*W-1:0] x_init;
  logic           busy;
  logic           done;
  logic [N-1:0]   out;
  logic           timeout;
  logic [IW-1:0]  iter;

  max_net_param #(.N(N), .W(W), .FRAC(FRAC), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .start(start), .eps(eps), .x_init(x_init),
    .busy(busy), .done(done), .out(out), .timeout(timeout), .iter(iter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] out;
    logic         to;
    int           iter;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack4(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                           input logic [W-1:0] a2, input logic [W-1:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // Reference MaxNet in wide arithmetic, iterating until one survivor or the limit.
  task automatic model(input logic [N*W-1:0] xi, input logic [W-1:0] e, output exp_t r);
    logic [127:0] x [N];
    logic [127:0] nx [N];
    logic [127:0] s, inh;
    int cnt;
    for (int i = 0; i < N; i++)
      x[i] = xi[i*W + W - 1] ? 128'd0 : {96'd0, xi[i*W +: W]};
    r.iter = 0;
    forever begin
      cnt = 0;
      for (int i = 0; i < N; i++) if (x[i] != 0) cnt++;
      if (cnt <= 1 || r.iter == MAX_ITER) break;
      s = 0;
      for (int i = 0; i < N; i++) s = s + x[i];
      for (int i = 0; i < N; i++) begin
        inh   = ({96'd0, e} * (s - x[i])) >> FRAC;
        nx[i] = (x[i] > inh) ? x[i] - inh : 128'd0;
      end
      for (int i = 0; i < N; i++) x[i] = nx[i];
      r.iter++;
    end
    r.to = (cnt > 1);
    for (int i = 0; i < N; i++) r.out[i] = (x[i] != 0);
`ifdef MAXNET_TIE_BREAK_EN
    if (r.to) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (x[i] != 0) begin
          r.out    = '0;
          r.out[i] = 1'b1;
        end
      end
    end
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_out"}, 64'(out), 64'd0);
    check_eq({tag, "_timeout"}, 64'(timeout), 64'd0);
    check_eq({tag, "_iter"}, 64'(iter), 64'd0);
  endtask

  // cyc counts negedges after the accepted start edge; done first seen at cyc == 3+3k.
  task automatic run(input logic [N*W-1:0] xi, input logic [W-1:0] e,
                     input int pulse_cyc, input int rst_cyc, input bit upd_chk);
    exp_t ex;
    exp_t got_ex;
    int   cyc;
    bit   ov;
    if (rst_cyc < 0) begin
      model(xi, e, ex);
      sb.push_back(ex);
    end
    @(negedge clk);
    x_init = xi;
    eps    = e;
    start  = 1'b1;
    @(negedge clk);
    cyc = 1;
    ov  = 1'b0;
    forever begin
      start = (cyc == pulse_cyc);
      if (busy && done) ov = 1'b1;
      if (cyc == 1) check_eq("done_drop", 64'(done), 64'd0);
      if (upd_chk && cyc == 5) begin
        check_eq("upd1_x0", 64'(dut.x_q[0]), 64'h0000D000);
        check_eq("upd1_x1", 64'(dut.x_q[1]), 64'h00004000);
        check_eq("upd1_x2", 64'(dut.x_q[2]), 64'h00000000);
        check_eq("upd1_x3", 64'(dut.x_q[3]), 64'h00008800);
      end
      if (cyc == rst_cyc) begin
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("rst_upd");
        return;
      end
      if (done || cyc > LIMIT) break;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check_eq("wait_done", 64'(done), 64'd1);
    got_ex = sb.pop_front();
    check_eq("out", 64'(out), 64'(got_ex.out));
    check_eq("timeout", 64'(timeout), 64'(got_ex.to));
    check_eq("iter", 64'(iter), 64'(got_ex.iter));
    check_eq("latency", 64'(cyc), 64'(3 + 3 * got_ex.iter));
    check_eq("busy_done_overlap", 64'(ov), 64'd0);
  endtask

  logic [N*W-1:0] main_x;
  logic [N*W-1:0] rx;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    eps    = '0;
    x_init = '0;
    main_x = pack4(32'h00010000, 32'h00008000, 32'h00004000, 32'h0000C000);
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    run(main_x, 32'h2000, -1, -1, 1'b1);
    check_eq("main_out_const", 64'(out), 64'h1);
    check_eq("main_iter_const", 64'(iter), 64'd7);
    run(pack4(32'h0, 32'h0, 32'h00008000, 32'h0), 32'h2000, -1, -1, 1'b0);
    check_eq("single_out_const", 64'(out), 64'h4);
    run(pack4(32'hFFFF0000, 32'h00004000, 32'h0, 32'h0), 32'h2000, -1, -1, 1'b0);
    check_eq("clamp_out_const", 64'(out), 64'h2);
    run('0, 32'h2000, -1, -1, 1'b0);
    run(pack4(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000), 32'h2000, -1, -1, 1'b0);
    check_eq("tie_timeout_const", 64'(timeout), 64'd1);
    check_eq("tie_iter_const", 64'(iter), 64'd8);

    run(main_x, 32'h2000, 3, -1, 1'b0);
    run(main_x, 32'h2000, -1, 4, 1'b0);
    run(main_x, 32'h2000, -1, -1, 1'b0);

    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_start");

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) rx[i*W +: W] = 32'hFFFF0000 - $urandom_range(0, 32'hFFFF);
        else                           rx[i*W +: W] = $urandom_range(0, 32'h20000);
      end
      run(rx, $urandom_range(32'h1000, 32'h8000), -1, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
